alu_muldiv: RTL and testbench

- Multi-cycle multiply/divide coprocessor. It sits beside the ALU on the same address-decoded bus and extends it with the operations the ALU cannot do in one bus cycle.
- Operands and a command are written through bus addresses. A shift-add multiplier or restoring divider then runs for 16 read_clk cycles.
- Results and status are read back onto the tristate data_bus using the same out_en/out_buffer discipline as the other bus peripherals.
- Its results feed the ALU operand registers and RAM through ordinary bus moves.

---
 rtl/alu_muldiv_pkg.sv | 28 ++
 rtl/alu_muldiv_md_core.sv | 103 ++++++++++
 rtl/alu_muldiv.sv | 93 +++++++++
 tb/tb_alu_muldiv.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the multiply/divide coprocessor: word width, bus addresses, op and state encodings.
package alu_muldiv_pkg;

    localparam int MD_WIDTH  = 16;
    localparam int MD_ITER   = MD_WIDTH;
    localparam int MD_ADDR_W = 16;

    // Placed above the ALU's 0x0000-0x003F window so decodes never overlap.
    localparam logic [MD_ADDR_W-1:0] MD_OP1    = 16'h0040;
    localparam logic [MD_ADDR_W-1:0] MD_OP2    = 16'h0041;
    localparam logic [MD_ADDR_W-1:0] MD_CMD    = 16'h0042;
    localparam logic [MD_ADDR_W-1:0] MD_MUL_LO = 16'h0043;
    localparam logic [MD_ADDR_W-1:0] MD_MUL_HI = 16'h0044;
    localparam logic [MD_ADDR_W-1:0] MD_QUO    = 16'h0045;
    localparam logic [MD_ADDR_W-1:0] MD_REM    = 16'h0046;
    localparam logic [MD_ADDR_W-1:0] MD_STATUS = 16'h0047;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/alu_muldiv_md_core.sv
// Iterative datapath: unsigned shift-add multiply or restoring divide, one bit per read_clk edge.
//   state   | meaning
//   ST_IDLE | waiting for start; working registers hold the last operation
//   ST_RUN  | iterating; done pulses on the final iteration with results on the step outputs
module md_core
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               read_clk,
    input  logic               reset,
    input  logic               start,
    input  md_op_e             op_sel,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               busy,
    output logic               done,
    output md_op_e             done_op,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_e          state, state_next;
    md_op_e             op_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod_q, prod_step;
    logic [WIDTH-1:0]   quo_q, quo_step;
    logic [WIDTH-1:0]   rem_q, rem_step;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH:0]     add_sum, rem_shift, rem_diff;

    // prod_q holds {partial product, unconsumed multiplier bits}; it shifts right each step.
    always_comb begin
        add_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opb_q} : '0);
        prod_step = {add_sum, prod_q[WIDTH-1:1]};
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opb_q};
        if (!rem_diff[WIDTH]) begin
            rem_step = rem_diff[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = rem_shift[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN: begin
                if (cnt == CW'(1)) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge read_clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            op_q   <= OP_MUL;
            cnt    <= '0;
            prod_q <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            opb_q  <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && start) begin
                op_q   <= op_sel;
                opb_q  <= op_b;
                prod_q <= {{WIDTH{1'b0}}, op_a};
                quo_q  <= op_a;
                rem_q  <= '0;
                cnt    <= CW'(MD_ITER);
            end else if (state == ST_RUN) begin
                cnt <= cnt - CW'(1);
                if (op_q == OP_MUL) begin
                    prod_q <= prod_step;
                end else begin
                    quo_q <= quo_step;
                    rem_q <= rem_step;
                end
            end
        end
    end

    assign busy      = (state == ST_RUN);
    assign done_op   = op_q;
    assign product   = prod_step;
    assign quotient  = quo_step;
    assign remainder = rem_step;
    assign div_zero  = (opb_q == '0);

endmodule

// File: rtl/alu_muldiv.sv
// Multiply/divide coprocessor on the address-decoded bus: operand/command decode, result registers,
// status word and the tristate read-back driver around the md_core datapath.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic                 read_clk,
    input  logic                 reset,
    input  logic [MD_ADDR_W-1:0] read_bus,
    input  logic [MD_ADDR_W-1:0] write_bus,
    inout  wire  [WIDTH-1:0]     data_bus
);

    logic [WIDTH-1:0]   op1, op2;
    logic [WIDTH-1:0]   mul_lo, mul_hi, quo, rem;
    logic               dz, err;
    logic               out_en;
    logic [WIDTH-1:0]   out_buffer;

    logic               busy, done, div_zero, wr_cmd, rd_hit;
    md_op_e             done_op;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient, remainder, status_word, rd_val;

    assign wr_cmd      = (write_bus == MD_CMD);
    assign status_word = {{(WIDTH-3){1'b0}}, err, dz, busy};

    md_core #(.WIDTH(WIDTH)) u_core (
        .read_clk  (read_clk),
        .reset     (reset),
        .start     (wr_cmd),
        .op_sel    (md_op_e'(data_bus[0])),
        .op_a      (op1),
        .op_b      (op2),
        .busy      (busy),
        .done      (done),
        .done_op   (done_op),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always_comb begin
        rd_hit = 1'b1;
        rd_val = '0;
        case (read_bus)
            MD_MUL_LO: rd_val = mul_lo;
            MD_MUL_HI: rd_val = mul_hi;
            MD_QUO:    rd_val = quo;
            MD_REM:    rd_val = rem;
            MD_STATUS: rd_val = status_word;
            default:   rd_hit = 1'b0;
        endcase
    end

    always_ff @(posedge read_clk or posedge reset) begin
        if (reset) begin
            op1        <= '0;
            op2        <= '0;
            mul_lo     <= '0;
            mul_hi     <= '0;
            quo        <= '0;
            rem        <= '0;
            dz         <= 1'b0;
            err        <= 1'b0;
            out_en     <= 1'b0;
            out_buffer <= '0;
        end else begin
            if (write_bus == MD_OP1) op1 <= data_bus;
            if (write_bus == MD_OP2) op2 <= data_bus;
            out_en <= rd_hit;
            if (rd_hit) out_buffer <= rd_val;
            if (done) begin
                if (done_op == OP_DIV) begin
                    quo <= quotient;
                    rem <= remainder;
                    dz  <= div_zero;
                end else begin
                    {mul_hi, mul_lo} <= product;
                    dz               <= 1'b0;
                end
            end
            // A rejected start on the same edge as a STATUS read must not be lost.
            if (wr_cmd && busy) err <= 1'b1;
            else if (read_bus == MD_STATUS) err <= 1'b0;
        end
    end

    assign data_bus = out_en ? out_buffer : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed and randomized bus-level bench for alu_muldiv against a cycle-level arithmetic reference model.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    localparam logic [15:0] IDLE = 16'h0000;

    logic        read_clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] read_bus = IDLE;
    logic [15:0] write_bus = IDLE;
    logic [15:0] tb_drive = '0;
    logic        tb_en = 1'b0;
    wire  [15:0] data_bus;

    assign data_bus = tb_en ? tb_drive : 16'hzzzz;

    alu_muldiv dut (
        .read_clk  (read_clk),
        .reset     (reset),
        .read_bus  (read_bus),
        .write_bus (write_bus),
        .data_bus  (data_bus)
    );

    always #5 read_clk = ~read_clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: what the bus should see after each edge.
    logic [15:0] m_op1, m_op2, m_lo, m_hi, m_quo, m_rem, m_out;
    logic        m_dz, m_err, m_out_en;
    int          m_left;
    logic        p_div, p_dz;
    logic [31:0] p_prod;
    logic [15:0] p_quo, p_rem;
    logic [15:0] addrs [7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_op1 = '0; m_op2 = '0; m_lo = '0; m_hi = '0; m_quo = '0; m_rem = '0;
        m_out = '0; m_dz = 1'b0; m_err = 1'b0; m_out_en = 1'b0; m_left = 0;
        p_div = 1'b0; p_dz = 1'b0; p_prod = '0; p_quo = '0; p_rem = '0;
    endtask

    task automatic model_edge();
        logic        busy_pre, err_n;
        logic [15:0] status;
        if (reset) begin
            model_reset();
            return;
        end
        busy_pre = (m_left != 0);
        status   = {13'b0, m_err, m_dz, busy_pre};
        err_n    = m_err;
        m_out_en = 1'b1;
        case (read_bus)
            MD_MUL_LO: m_out = m_lo;
            MD_MUL_HI: m_out = m_hi;
            MD_QUO:    m_out = m_quo;
            MD_REM:    m_out = m_rem;
            MD_STATUS: begin m_out = status; err_n = 1'b0; end
            default:   m_out_en = 1'b0;
        endcase
        if (m_left != 0) begin
            m_left--;
            if (m_left == 0) begin
                if (p_div) begin
                    m_quo = p_quo; m_rem = p_rem; m_dz = p_dz;
                end else begin
                    {m_hi, m_lo} = p_prod; m_dz = 1'b0;
                end
            end
        end
        if (tb_en) begin
            if (write_bus == MD_OP1) m_op1 = tb_drive;
            if (write_bus == MD_OP2) m_op2 = tb_drive;
            if (write_bus == MD_CMD) begin
                if (busy_pre) err_n = 1'b1;
                else begin
                    p_div = tb_drive[0];
                    p_dz  = (m_op2 == 0);
                    if (m_op2 == 0) begin
                        p_quo = 16'hFFFF; p_rem = m_op1;
                    end else begin
                        p_quo = m_op1 / m_op2; p_rem = m_op1 % m_op2;
                    end
                    p_prod = 32'(m_op1) * 32'(m_op2);
                    m_left = 16;
                end
            end
        end
        m_err = err_n;
    endtask

    task automatic tick();
        model_edge();
        @(posedge read_clk);
        #1;
    endtask

    task automatic idle(input int n);
        read_bus = IDLE;
        repeat (n) tick();
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] d);
        if (m_out_en) idle(1);
        write_bus = addr; tb_drive = d; tb_en = 1'b1;
        tick();
        write_bus = IDLE; tb_en = 1'b0;
    endtask

    task automatic rd(input logic [15:0] addr, input string tag, output logic [15:0] val);
        read_bus = addr;
        tick();
        read_bus = IDLE;
        val = data_bus;
        check({tag, "_en"}, 32'(dut.out_en), 32'(m_out_en));
        if (m_out_en) check(tag, 32'(data_bus), 32'(m_out));
    endtask

    initial begin
        logic [15:0] v, a, b;
        int k;
        addrs[0] = IDLE;      addrs[1] = MD_MUL_LO; addrs[2] = MD_MUL_HI; addrs[3] = MD_QUO;
        addrs[4] = MD_REM;    addrs[5] = MD_STATUS; addrs[6] = 16'h0013;
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge read_clk);
        #1;
        check("reset_out_en", 32'(dut.out_en), 32'd0);
        reset = 1'b0;

        // Reset mid-multiply aborts without committing.
        bus_write(MD_OP1, 16'd7);
        bus_write(MD_OP2, 16'd9);
        bus_write(MD_CMD, 16'd0);
        idle(4);
        #2 reset = 1'b1;
        #1 model_reset();
        check("abort_out_en", 32'(dut.out_en), 32'd0);
        reset = 1'b0;
        rd(MD_STATUS, "abort_status", v); check("abort_status_c", 32'(v), 32'h0000);
        rd(MD_MUL_LO, "abort_lo", v);     check("abort_lo_c", 32'(v), 32'h0000);
        rd(MD_MUL_HI, "abort_hi", v);     check("abort_hi_c", 32'(v), 32'h0000);
        rd(MD_QUO, "abort_quo", v);       check("abort_quo_c", 32'(v), 32'h0000);
        rd(MD_REM, "abort_rem", v);       check("abort_rem_c", 32'(v), 32'h0000);

        // FFFF x FFFF with STATUS polled every edge to pin down the busy window.
        bus_write(MD_OP1, 16'hFFFF);
        bus_write(MD_OP2, 16'hFFFF);
        bus_write(MD_CMD, 16'd0);
        for (int i = 1; i <= 17; i++) begin
            rd(MD_STATUS, "mul_busy", v);
            check("mul_busy_c", 32'(v), (i <= 16) ? 32'h0001 : 32'h0000);
        end
        rd(MD_MUL_HI, "mul_hi", v); check("mul_hi_c", 32'(v), 32'hFFFE);
        rd(MD_MUL_LO, "mul_lo", v); check("mul_lo_c", 32'(v), 32'h0001);

        bus_write(MD_OP1, 16'd1000);
        bus_write(MD_OP2, 16'd7);
        bus_write(MD_CMD, 16'd1);
        idle(16);
        rd(MD_QUO, "div_quo", v);       check("div_quo_c", 32'(v), 32'd142);
        rd(MD_REM, "div_rem", v);       check("div_rem_c", 32'(v), 32'd6);
        rd(MD_STATUS, "div_status", v); check("div_status_c", 32'(v), 32'h0000);

        bus_write(MD_OP1, 16'd1234);
        bus_write(MD_OP2, 16'd0);
        bus_write(MD_CMD, 16'd1);
        idle(16);
        rd(MD_QUO, "dz_quo", v);       check("dz_quo_c", 32'(v), 32'hFFFF);
        rd(MD_REM, "dz_rem", v);       check("dz_rem_c", 32'(v), 32'd1234);
        rd(MD_STATUS, "dz_status", v); check("dz_status_c", 32'(v), 32'h0002);

        // Busy collision: operand rewrite and rejected start during the run.
        bus_write(MD_OP1, 16'd3);
        bus_write(MD_OP2, 16'd5);
        bus_write(MD_CMD, 16'd0);
        idle(2);
        bus_write(MD_OP1, 16'd100);
        bus_write(MD_CMD, 16'd1);
        idle(12);
        rd(MD_MUL_LO, "col_lo", v);      check("col_lo_c", 32'(v), 32'd15);
        rd(MD_STATUS, "col_status", v);  check("col_status_c", 32'(v), 32'h0004);
        rd(MD_STATUS, "col_status2", v); check("col_status2_c", 32'(v), 32'h0000);

        // CMD on the commit edge itself is still rejected.
        bus_write(MD_CMD, 16'd0);
        idle(15);
        bus_write(MD_CMD, 16'd0);
        rd(MD_STATUS, "edge_status", v); check("edge_status_c", 32'(v), 32'h0004);
        rd(MD_MUL_LO, "edge_lo", v);     check("edge_lo_c", 32'(v), 32'd500);

        // Stale read during a run returns the previous result.
        bus_write(MD_OP1, 16'd10);
        bus_write(MD_OP2, 16'd10);
        bus_write(MD_CMD, 16'd0);
        idle(17);
        bus_write(MD_OP1, 16'd2);
        bus_write(MD_OP2, 16'd3);
        bus_write(MD_CMD, 16'd0);
        idle(7);
        rd(MD_MUL_LO, "stale_lo", v); check("stale_lo_c", 32'(v), 32'd100);
        idle(8);
        rd(MD_MUL_LO, "fresh_lo", v); check("fresh_lo_c", 32'(v), 32'd6);
        idle(1);
        check("drop_out_en", 32'(dut.out_en), 32'd0);

        // Randomized operations with interleaved reads, operand rewrites and colliding starts.
        for (int op = 0; op < 25; op++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
            bus_write(MD_OP1, a);
            bus_write(MD_OP2, b);
            bus_write(MD_CMD, 16'($urandom_range(0, 1)));
            for (int c = 0; c < 18; c++) begin
                k = $urandom_range(0, 12);
                if (k == 12) bus_write(MD_CMD, 16'($urandom_range(0, 1)));
                else if (k == 11) bus_write(MD_OP2, 16'($urandom));
                else rd(addrs[k % 7], "rand", v);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
